// File: rtl/frontend_command_definition_pkg.sv
// Shared types for the frontend-to-backend command channel: operation type,
// command payload and the default channel geometry.
package frontend_command_definition_pkg;

  localparam int FRONTEND_ROW_W     = 16;
  localparam int FRONTEND_COL_W     = 4;
  localparam int FRONTEND_DATA_W    = 128;
  localparam int FRONTEND_RDQ_DEPTH = 4;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_type_t;

  typedef struct packed {
    op_type_t                    op_type;
    logic [FRONTEND_ROW_W-1:0]   row_addr;
    logic [FRONTEND_COL_W-1:0]   col_addr;
  } backend_command_t;

endpackage

// File: rtl/frontend_cmd_issuer_rd_return_fifo.sv
// First-word-fall-through FIFO holding returned read bursts until the
// requester takes them; DEPTH must be a power of two so pointers wrap freely.
module rd_return_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/frontend_cmd_issuer.sv
// Issues single-beat frontend requests to the backend under valid/ready and
// returns read data in order; power_on_rst is expected to be released in sync with clk.
module frontend_cmd_issuer
  import frontend_command_definition_pkg::*;
#(
  parameter int ROW_W     = FRONTEND_ROW_W,
  parameter int COL_W     = FRONTEND_COL_W,
  parameter int DATA_W    = FRONTEND_DATA_W,
  parameter int RDQ_DEPTH = FRONTEND_RDQ_DEPTH
) (
  input  logic              clk,
  input  logic              power_on_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  op_type_t          i_req_op,
  input  logic [ROW_W-1:0]  i_req_row,
  input  logic [COL_W-1:0]  i_req_col,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_frontend_command_valid,
  output backend_command_t  o_frontend_command,
  output logic [DATA_W-1:0] o_frontend_write_data,
  input  logic              i_backend_controller_ready,
  input  logic [DATA_W-1:0] i_backend_read_data,
  input  logic              i_backend_read_data_valid,
  output logic              o_backend_controller_ren,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_idle,
  output logic              o_err_unexpected_rd
);

  localparam int CNT_W = $clog2(RDQ_DEPTH) + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  backend_command_t  r_cmd;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_outstanding;
  logic              r_err_unexpected_rd;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [CNT_W:0]    w_credit_sum;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pending_read;
  logic              w_credit_exhausted;
  logic              w_xfer;
  logic              w_req_ready;
  logic              w_req_fire;
  logic              w_rd_cmd_xfer;
  logic              w_rd_data_xfer;
  logic              w_rd_data_expected;
  logic              w_rsp_pop;

  // A read is only admitted if its burst is guaranteed a FIFO slot.
  assign w_pending_read     = (r_state == S_ISSUE) && (r_cmd.op_type == OP_READ);
  assign w_credit_sum       = (CNT_W+1)'(r_outstanding) + (CNT_W+1)'(w_fifo_count)
                            + (CNT_W+1)'(w_pending_read);
  assign w_credit_exhausted = (w_credit_sum >= (CNT_W+1)'(RDQ_DEPTH));

  assign w_xfer             = (r_state == S_ISSUE) && i_backend_controller_ready;
  assign w_rd_cmd_xfer      = w_xfer && (r_cmd.op_type == OP_READ);
  assign w_req_fire         = i_req_valid && w_req_ready;
  assign w_rd_data_xfer     = i_backend_read_data_valid && o_backend_controller_ren;
  assign w_rd_data_expected = w_rd_data_xfer && (r_outstanding != '0);
  assign w_rsp_pop          = !w_fifo_empty && i_rsp_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = !((i_req_op == OP_READ) && w_credit_exhausted);
        w_state_nxt = (i_req_valid && w_req_ready) ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        if (w_xfer) begin
          w_req_ready = !((i_req_op == OP_READ) && w_credit_exhausted);
          w_state_nxt = (i_req_valid && w_req_ready) ? S_ISSUE : S_IDLE;
        end else begin
          w_req_ready = 1'b0;
          w_state_nxt = S_ISSUE;
        end
      end
      default: begin
        w_req_ready = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      r_cmd   <= '0;
      r_wdata <= '0;
    end else if (w_req_fire) begin
      r_cmd   <= '{op_type: i_req_op, row_addr: i_req_row, col_addr: i_req_col};
      r_wdata <= i_req_wdata;
    end
  end

  // Data with nothing outstanding is dropped and flagged; it never decrements.
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      r_outstanding       <= '0;
      r_err_unexpected_rd <= 1'b0;
    end else begin
      if (w_rd_data_xfer && (r_outstanding == '0)) r_err_unexpected_rd <= 1'b1;
      if (w_rd_cmd_xfer && !w_rd_data_expected)      r_outstanding <= r_outstanding + 1'b1;
      else if (!w_rd_cmd_xfer && w_rd_data_expected) r_outstanding <= r_outstanding - 1'b1;
    end
  end

  rd_return_fifo #(
    .DEPTH (RDQ_DEPTH),
    .WIDTH (DATA_W)
  ) u_rd_return_fifo (
    .clk     (clk),
    .rst     (power_on_rst),
    .i_push  (w_rd_data_expected),
    .i_data  (i_backend_read_data),
    .i_pop   (w_rsp_pop),
    .o_data  (o_rsp_rdata),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_req_ready              = w_req_ready;
  assign o_frontend_command_valid = (r_state == S_ISSUE);
  assign o_frontend_command       = r_cmd;
  assign o_frontend_write_data    = r_wdata;
  assign o_backend_controller_ren = !w_fifo_full && !power_on_rst;
  assign o_rsp_valid              = !w_fifo_empty;
  assign o_idle                   = (r_state == S_IDLE) && (r_outstanding == '0) && w_fifo_empty;
  assign o_err_unexpected_rd      = r_err_unexpected_rd;

endmodule

// File: tb/tb_frontend_cmd_issuer.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_frontend_cmd_issuer;
  import frontend_command_definition_pkg::*;

  localparam int RDQ = FRONTEND_RDQ_DEPTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  op_type_t         req_op = OP_WRITE;
  logic [15:0]      req_row = 16'd0;
  logic [3:0]       req_col = 4'd0;
  logic [127:0]     req_wdata = 128'd0;
  logic             bready = 1'b0;
  logic [127:0]     rd_data = 128'd0;
  logic             rd_valid = 1'b0;
  logic             rsp_ready = 1'b0;

  logic             o_req_ready;
  logic             o_cmd_valid;
  backend_command_t o_cmd;
  logic [127:0]     o_wdata;
  logic             o_ren;
  logic             o_rsp_valid;
  logic [127:0]     o_rsp_rdata;
  logic             o_idle;
  logic             o_err;

  always #5 clk = ~clk;

  frontend_cmd_issuer dut (
    .clk                        (clk),
    .power_on_rst               (rst),
    .i_req_valid                (req_valid),
    .o_req_ready                (o_req_ready),
    .i_req_op                   (req_op),
    .i_req_row                  (req_row),
    .i_req_col                  (req_col),
    .i_req_wdata                (req_wdata),
    .o_frontend_command_valid   (o_cmd_valid),
    .o_frontend_command         (o_cmd),
    .o_frontend_write_data      (o_wdata),
    .i_backend_controller_ready (bready),
    .i_backend_read_data        (rd_data),
    .i_backend_read_data_valid  (rd_valid),
    .o_backend_controller_ren   (o_ren),
    .o_rsp_valid                (o_rsp_valid),
    .i_rsp_ready                (rsp_ready),
    .o_rsp_rdata                (o_rsp_rdata),
    .o_idle                     (o_idle),
    .o_err_unexpected_rd        (o_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one pending command slot, reads in flight, returned data queue.
  bit           m_busy = 1'b0;
  op_type_t     m_op = OP_READ;
  logic [15:0]  m_row = 16'd0;
  logic [3:0]   m_col = 4'd0;
  logic [127:0] m_wdata = 128'd0;
  int           m_out = 0;
  logic [127:0] m_q[$];
  bit           m_err = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_exhausted();
    int pend;
    pend = (m_busy && m_op == OP_READ) ? 1 : 0;
    return (m_out + m_q.size() + pend) >= RDQ;
  endfunction

  function automatic bit m_req_ready();
    return (!m_busy || bready) && !(req_op == OP_READ && m_exhausted());
  endfunction

  function automatic bit m_ren();
    return !rst && (m_q.size() < RDQ);
  endfunction

  initial forever begin
    bit fire, xfer, dx, pop;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 1'b0; m_out = 0; m_err = 1'b0; m_q.delete();
    end else begin
      fire = req_valid && m_req_ready();
      xfer = m_busy && bready;
      dx   = rd_valid && m_ren();
      pop  = (m_q.size() > 0) && rsp_ready;
      if (pop) void'(m_q.pop_front());
      if (dx) begin
        if (m_out == 0) m_err = 1'b1;
        else begin m_out--; m_q.push_back(rd_data); end
      end
      if (xfer && m_op == OP_READ) m_out++;
      if (fire) begin
        m_busy = 1'b1; m_op = req_op; m_row = req_row; m_col = req_col; m_wdata = req_wdata;
      end else if (xfer) begin
        m_busy = 1'b0;
      end
    end
  end

  // Every cycle, on the falling edge, every output against the model.
  initial forever begin
    @(negedge clk);
    check("m_req_ready", o_req_ready, m_req_ready());
    check("m_cmd_valid", o_cmd_valid, m_busy);
    if (m_busy) check("m_cmd", o_cmd, {m_op, m_row, m_col});
    if (m_busy && m_op == OP_WRITE) check("m_wdata", o_wdata, m_wdata);
    check("m_ren", o_ren, m_ren());
    check("m_rsp_valid", o_rsp_valid, m_q.size() > 0);
    if (m_q.size() > 0) check("m_rsp_rdata", o_rsp_rdata, m_q[0]);
    check("m_idle", o_idle, !m_busy && m_out == 0 && m_q.size() == 0);
    check("m_err", o_err, m_err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] bursts [4];

  initial begin
    bursts[0] = 128'hAAAA_0000_0000_0000_0000_0000_0000_000A;
    bursts[1] = 128'hBBBB_0000_0000_0000_0000_0000_0000_000B;
    bursts[2] = 128'hCCCC_0000_0000_0000_0000_0000_0000_000C;
    bursts[3] = 128'hDDDD_0000_0000_0000_0000_0000_0000_000D;

    // Reset values.
    tick();
    check("rst_req_ready", o_req_ready, 1'b1);
    check("rst_idle", o_idle, 1'b1);
    check("rst_cmd_valid", o_cmd_valid, 1'b0);
    check("rst_ren", o_ren, 1'b0);
    check("rst_rsp_valid", o_rsp_valid, 1'b0);
    check("rst_cmd", o_cmd, 21'd0);
    tick();
    rst = 1'b0;
    tick();

    // Write held against a stalled backend.
    req_valid = 1'b1; req_op = OP_WRITE; req_row = 16'd5; req_col = 4'd3; req_wdata = 128'h1234;
    #1;
    check("t1_req_ready", o_req_ready, 1'b1);
    check("t1_valid_pre", o_cmd_valid, 1'b0);
    tick();
    req_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t1_hold_valid", o_cmd_valid, 1'b1);
      check("t1_hold_cmd", o_cmd, {OP_WRITE, 16'd5, 4'd3});
      check("t1_hold_wdata", o_wdata, 128'h1234);
      check("t1_idle_busy", o_idle, 1'b0);
      tick();
      #1;
    end
    bready = 1'b1;
    #1;
    check("t1_xfer_valid", o_cmd_valid, 1'b1);
    check("t1_xfer_cmd", o_cmd, {OP_WRITE, 16'd5, 4'd3});
    tick();
    #1;
    check("t1_after_valid", o_cmd_valid, 1'b0);
    check("t1_after_idle", o_idle, 1'b1);

    // Four back-to-back reads, fifth blocked by credit.
    req_valid = 1'b1; req_op = OP_READ; req_row = 16'd1; req_col = 4'd15;
    #1;
    check("t2_ready_first", o_req_ready, 1'b1);
    for (int r = 2; r <= 4; r++) begin
      tick();
      req_row = 16'(r);
      #1;
      check("t2_ready", o_req_ready, 1'b1);
      check("t2_valid", o_cmd_valid, 1'b1);
      check("t2_cmd", o_cmd, {OP_READ, 16'(r - 1), 4'd15});
    end
    tick();
    req_row = 16'd5;
    #1;
    check("t2_last_valid", o_cmd_valid, 1'b1);
    check("t2_last_cmd", o_cmd, {OP_READ, 16'd4, 4'd15});
    check("t2_fifth_blocked", o_req_ready, 1'b0);
    tick();
    #1;
    check("t2_model_peak", 128'(m_out), 128'd4);
    check("t2_idle_valid", o_cmd_valid, 1'b0);
    check("t2_still_blocked", o_req_ready, 1'b0);
    check("t2_not_idle", o_idle, 1'b0);

    // Four bursts fill the FIFO while the requester stalls.
    for (int i = 0; i < 4; i++) begin
      rd_valid = 1'b1; rd_data = bursts[i];
      #1;
      check("t3_ren", o_ren, 1'b1);
      check("t3_blocked", o_req_ready, 1'b0);
      tick();
    end
    rd_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    check("t3_ren_full", o_ren, 1'b0);
    check("t3_rsp_a", o_rsp_rdata, bursts[0]);
    check("t3_blocked_full", o_req_ready, 1'b0);
    tick();
    #1;
    check("t3_rsp_b", o_rsp_rdata, bursts[1]);
    check("t3_fifth_ready", o_req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    #1;
    check("t3_rsp_c", o_rsp_rdata, bursts[2]);
    check("t3_fifth_cmd", o_cmd, {OP_READ, 16'd5, 4'd15});
    tick();
    #1;
    check("t3_rsp_d", o_rsp_rdata, bursts[3]);
    tick();
    #1;
    check("t3_drained", o_rsp_valid, 1'b0);
    rd_valid = 1'b1; rd_data = 128'hE;
    tick();
    rd_valid = 1'b0;
    #1;
    check("t3_rsp_e", o_rsp_rdata, 128'hE);
    tick();
    #1;
    check("t3_idle", o_idle, 1'b1);

    // Read command and read data transfer in the same cycle.
    rsp_ready = 1'b0; bready = 1'b1; req_valid = 1'b1; req_op = OP_READ; req_col = 4'd0;
    req_row = 16'd10;
    tick();
    req_row = 16'd11;
    tick();
    req_row = 16'd12;
    tick();
    req_valid = 1'b0; bready = 1'b0;
    tick();
    bready = 1'b1; rd_valid = 1'b1; rd_data = 128'hF0;
    #1;
    check("t4_model_out", 128'(m_out), 128'd2);
    check("t4_valid", o_cmd_valid, 1'b1);
    check("t4_ren", o_ren, 1'b1);
    tick();
    bready = 1'b0; rd_valid = 1'b0;
    #1;
    check("t4_model_out_after", 128'(m_out), 128'd2);
    check("t4_credit", o_req_ready, 1'b1);
    check("t4_rsp_f0", o_rsp_rdata, 128'hF0);
    rd_valid = 1'b1; rd_data = 128'hF1;
    tick();
    rd_data = 128'hF2;
    tick();
    rd_valid = 1'b0;
    #1;
    check("t4_no_err", o_err, 1'b0);
    check("t4_credit_3", o_req_ready, 1'b1);
    rsp_ready = 1'b1;
    #1;
    check("t4_pop_f0", o_rsp_rdata, 128'hF0);
    tick();
    #1;
    check("t4_pop_f1", o_rsp_rdata, 128'hF1);
    tick();
    #1;
    check("t4_pop_f2", o_rsp_rdata, 128'hF2);
    tick();
    #1;
    check("t4_empty", o_rsp_valid, 1'b0);
    check("t4_idle", o_idle, 1'b1);
    rsp_ready = 1'b0;

    // Unexpected read data.
    rd_valid = 1'b1; rd_data = 128'hDEAD;
    tick();
    rd_valid = 1'b0;
    #1;
    check("t5_err", o_err, 1'b1);
    check("t5_fifo_empty", o_rsp_valid, 1'b0);
    check("t5_idle", o_idle, 1'b1);
    tick();
    tick();
    #1;
    check("t5_err_sticky", o_err, 1'b1);
    check("t5_idle_sticky", o_idle, 1'b1);

    // Reset with reads in flight and a command pending.
    bready = 1'b1; req_valid = 1'b1; req_op = OP_READ; req_row = 16'd20;
    tick();
    req_row = 16'd21;
    tick();
    req_row = 16'd22;
    tick();
    bready = 1'b0;
    #1;
    check("t6_pending", o_cmd_valid, 1'b1);
    check("t6_model_out", 128'(m_out), 128'd2);
    rst = 1'b1;
    #1;
    check("t6_valid", o_cmd_valid, 1'b0);
    check("t6_ready", o_req_ready, 1'b1);
    check("t6_idle", o_idle, 1'b1);
    check("t6_ren", o_ren, 1'b0);
    check("t6_err", o_err, 1'b0);
    check("t6_cmd", o_cmd, 21'd0);
    check("t6_rdata", o_rsp_rdata, 128'd0);
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t6_rel_idle", o_idle, 1'b1);
    check("t6_rel_ready", o_req_ready, 1'b1);

    // Randomized traffic; the backend only returns data for reads in flight.
    for (int c = 0; c < 3000; c++) begin
      tick();
      req_valid = 1'($urandom_range(0, 1));
      req_op    = op_type_t'($urandom_range(0, 1));
      req_row   = 16'($urandom);
      req_col   = 4'($urandom);
      req_wdata = {$urandom, $urandom, $urandom, $urandom};
      bready    = ($urandom_range(0, 3) != 0);
      rd_valid  = (m_out > 0) && ($urandom_range(0, 2) == 0);
      rd_data   = {$urandom, $urandom, $urandom, $urandom};
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
    tick();
    req_valid = 1'b0; rd_valid = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frontend_cmd_issuer.md
Name: frontend_cmd_issuer

Overview:
- Initiator on the frontend-to-backend command channel; the counterpart of the backend controller's command and read-data ports.
- Accepts single-beat read/write requests from the frontend request queue and issues them as backend_command_t with write data under a valid/ready handshake.
- Tracks outstanding reads with a credit counter, drains returned read data into a local FIFO via the ren strobe, and returns read data in order to the requester.

Parameters:
- ROW_W, 16, row address width of backend_command_t.row_addr.
- COL_W, 4, column address width of backend_command_t.col_addr (burst slots 0..15).
- DATA_W, 128, burst data width (DQ_BITS*8).
- RDQ_DEPTH, 4, read-return FIFO depth; also the maximum reads in flight plus buffered (power of 2, at least 2).

Ports:
- clk, in, 1, single system clock.
- power_on_rst, in, 1, asynchronous active-high reset.
- i_req_valid, in, 1, request present.
- o_req_ready, out, 1, request accepted when i_req_valid and o_req_ready are both high.
- i_req_op, in, op_type_t, OP_READ or OP_WRITE.
- i_req_row, in, ROW_W, row address.
- i_req_col, in, COL_W, column slot.
- i_req_wdata, in, DATA_W, write burst data (ignored for reads).
- o_frontend_command_valid, out, 1, command valid to backend.
- o_frontend_command, out, backend_command_t, {op_type, row_addr, col_addr}.
- o_frontend_write_data, out, DATA_W, write burst aligned with the command.
- i_backend_controller_ready, in, 1, backend ready.
- i_backend_read_data, in, DATA_W, returned read burst.
- i_backend_read_data_valid, in, 1, read burst present.
- o_backend_controller_ren, out, 1, read-data accept strobe.
- o_rsp_valid, out, 1, read response valid.
- i_rsp_ready, in, 1, requester accepts the response.
- o_rsp_rdata, out, DATA_W, read response data.
- o_idle, out, 1, no pending command, no read in flight, FIFO empty.
- o_err_unexpected_rd, out, 1, sticky: read data arrived with zero reads outstanding.

Behaviour:
- Reset: asynchronous assert, synchronous release. State is IDLE. Command register, outstanding counter and FIFO are cleared. Every output is 0 except o_req_ready=1 and o_idle=1.
- State machine has two states: IDLE and ISSUE.
  - IDLE: o_req_ready = !(i_req_op==OP_READ && rd_credit_exhausted). On a request handshake, capture op/row/col/wdata into the command register and go to ISSUE. Capture latency is 1 cycle; no combinational path from request to command outputs.
  - ISSUE: o_frontend_command_valid=1 and the payload is held stable. A transfer occurs on the cycle where valid and i_backend_controller_ready are both high. valid must never drop before the transfer, even if ready toggles.
  - On transfer, if i_req_valid is high and credit allows, capture the next request in the same cycle and stay in ISSUE (back-to-back, 1 command/cycle). Otherwise go to IDLE.
  - o_req_ready is low in ISSUE except on a transfer cycle.
- Credits: rd_credit_exhausted = (outstanding + fifo_count + pending_read) >= RDQ_DEPTH. A read is never accepted without guaranteed FIFO space. Writes ignore credits.
- Outstanding counter (log2(RDQ_DEPTH)+1 bits):
  - +1 on a read command transfer.
  - -1 on a read-data transfer (i_backend_read_data_valid && ren).
  - Unchanged when both happen in the same cycle.
  - Saturates at 0. A decrement at 0 sets o_err_unexpected_rd (cleared only by reset) and the data is dropped.
- o_backend_controller_ren = !fifo_full, registered-free. Data is written to the FIFO on valid&&ren.
- Response side: o_rsp_valid = !fifo_empty, o_rsp_rdata = FIFO head (first-word-fall-through). Pop on o_rsp_valid && i_rsp_ready. Simultaneous push and pop keeps the count. Pointers wrap modulo RDQ_DEPTH.
- o_idle = (state==IDLE) && outstanding==0 && fifo_empty.
- Reset mid-transfer discards in-flight reads; the backend shares the same reset.

Decomposition:
- Shared package (frontend_command_definition_pkg): op_type_t (OP_READ/OP_WRITE) and backend_command_t. Add a FRONTEND_RDQ_DEPTH constant there.
- One sub-module: rd_return_fifo (synchronous FWFT FIFO with DEPTH and WIDTH parameters, count/full/empty outputs).

Test Plan:
- Write 0x1234 at row 5, col 3, with backend ready stuck low for 4 cycles, then high. Command valid is held with a stable payload for 5 cycles and transfers once. outstanding stays 0. o_idle returns to 1 the cycle after transfer.
- 4 reads (rows 1..4, col 15) with backend ready always 1. 4 transfers in 4 consecutive cycles; a 5th read request sees o_req_ready=0 until a response pops. outstanding peaks at 4.
- Backend returns 4 bursts A,B,C,D while i_rsp_ready=0. FIFO fills and ren drops to 0 after D. Raising i_rsp_ready yields A,B,C,D in order on 4 consecutive cycles.
- Same-cycle read command transfer and read-data transfer with outstanding=2. outstanding stays 2 and the FIFO count increments by 1.
- Read-data valid while outstanding=0. o_err_unexpected_rd=1 stays sticky, the FIFO stays empty, and the counter stays 0.
- Assert power_on_rst with 2 reads in flight and valid high. All outputs return to reset values immediately; after release, o_idle=1 and o_req_ready=1.
